// File: rtl/balanca_preco_ctrl_pkg.sv
// Purpose : shared types, widths and helpers for the scale pricing controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package balanca_preco_ctrl_pkg;

  localparam int W_GRAMS      = 12;    // grams and cents-per-kg operands
  localparam int W_PRICE      = 19;    // final price in cents
  localparam int W_ACC        = 25;    // product 4095*4095 plus rounding fits
  localparam int GRAMS_PER_KG = 1000;
  localparam int ROUND_HALF   = 500;   // added before the divide: round half up
  localparam int DIV_STEPS    = 25;    // one restoring step per dividend bit

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MUL,
    DIV,
    DONE
  } state_e;

  typedef struct packed {
    logic [9:0]       rem;
    logic [W_ACC-1:0] quo;
  } div_step_t;

  // One restoring-division step by GRAMS_PER_KG. The quotient register doubles
  // as the dividend shifter: its MSB feeds the partial remainder and the new
  // quotient bit enters at the LSB.
  function automatic div_step_t div_step(input logic [9:0] rem,
                                         input logic [W_ACC-1:0] quo);
    logic [10:0] r;
    div_step_t   s;
    r     = {rem, quo[W_ACC-1]};
    s.quo = {quo[W_ACC-2:0], 1'b0};
    if (r >= 11'(GRAMS_PER_KG)) begin
      r        = r - 11'(GRAMS_PER_KG);
      s.quo[0] = 1'b1;
    end
    s.rem = r[9:0];
    return s;
  endfunction

endpackage

// File: rtl/balanca_preco_ctrl_if.sv
// Purpose : sampler/price-request/result bundle between the scale front end and the pricing controller.
// Latency : n/a (wires only).
// Backpressure: none; start/tareBtn are single-cycle requests, precoValid a single-cycle pulse.
// master drives weight, unit price and requests; slave (the controller) drives results and status.
interface balanca_preco_ctrl_if;
  import balanca_preco_ctrl_pkg::*;

  logic [W_GRAMS-1:0] weightInGrams;
  logic [W_GRAMS-1:0] centimos;
  logic               start;
  logic               tareBtn;
  logic [W_GRAMS-1:0] netGrams;
  logic [W_PRICE-1:0] precof;
  logic               precoValid;
  logic               busy;
  logic               overload;
  logic               errTimeout;

  modport master (
    output weightInGrams, centimos, start, tareBtn,
    input  netGrams, precof, precoValid, busy, overload, errTimeout
  );

  modport slave (
    input  weightInGrams, centimos, start, tareBtn,
    output netGrams, precof, precoValid, busy, overload, errTimeout
  );

endinterface

// File: rtl/balanca_div1000_seq.sv
// Purpose : sequential restoring divide of a 25-bit dividend by 1000.
// Latency : start edge performs step 1; quotient and done are valid in the cycle before the 25th edge.
// Backpressure: none; start is ignored while a division is running.
// Ports: clk, rst_n, start (1-cycle), dividend[24:0] in; done (1-cycle, combinational), quotient[18:0] out.
module balanca_div1000_seq
  import balanca_preco_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_ACC-1:0]   dividend,
  output logic               done,
  output logic [W_PRICE-1:0] quotient
);

  logic             running;
  logic [4:0]       step_cnt;
  logic [9:0]       rem;
  logic [W_ACC-1:0] quo;
  div_step_t        nxt;

  // The loading edge already performs the first step, so the last step's
  // result is exposed combinationally and the whole divide spans 25 edges.
  always_comb begin
    nxt = div_step(running ? rem : '0, running ? quo : dividend);
  end

  assign done     = running && (step_cnt == 5'(DIV_STEPS - 1));
  assign quotient = nxt.quo[W_PRICE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      step_cnt <= '0;
      rem      <= '0;
      quo      <= '0;
    end else if (running) begin
      rem <= nxt.rem;
      quo <= nxt.quo;
      if (done) running  <= 1'b0;
      else      step_cnt <= step_cnt + 5'd1;
    end else if (start) begin
      running  <= 1'b1;
      step_cnt <= 5'd1;
      rem      <= nxt.rem;
      quo      <= nxt.quo;
    end
  end

endmodule

// File: rtl/balanca_preco_ctrl.sv
// Purpose : pricing sequencer: wait for stable weight, apply tare, price = round(net*centimos/1000).
// Latency : precoValid 1+STABLE_CYCLES+12+25 edges after start with a steady weight; 1+STABLE_CYCLES on overload.
// Backpressure: none; start/tareBtn only honoured in IDLE (busy low), never queued.
// Ports: clk, rst_n plain; bus (slave) carries weight/price/requests in, netGrams/precof/precoValid/
//        busy/overload/errTimeout out.
module balanca_preco_ctrl
  import balanca_preco_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int SETTLE_TIMEOUT = 255,
  parameter int MAX_GRAMS      = 4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  balanca_preco_ctrl_if.slave  bus
);

  localparam logic [15:0]        STABLE_W = 16'(STABLE_CYCLES);
  localparam logic [15:0]        TMO_W    = 16'(SETTLE_TIMEOUT);
  localparam logic [W_GRAMS-1:0] MAX_W    = W_GRAMS'(MAX_GRAMS);
  localparam logic [3:0]         LAST_BIT = 4'(W_GRAMS - 1);
  localparam logic [W_ACC-1:0]   ROUND_W  = W_ACC'(ROUND_HALF);

  state_e             state;
  logic [W_GRAMS-1:0] tare;
  logic [W_GRAMS-1:0] last_w;
  logic [W_GRAMS-1:0] op_b;
  logic [W_GRAMS-1:0] net_now;
  logic [15:0]        cnt;
  logic [15:0]        tmo;
  logic [3:0]         bit_idx;
  logic [W_ACC-1:0]   acc;
  logic [W_ACC-1:0]   acc_next;
  logic               div_start;
  logic               div_done;
  logic [W_PRICE-1:0] div_quo;

  // Tare larger than the reading shows as zero net rather than wrapping.
  assign net_now = (last_w >= tare) ? (last_w - tare) : '0;

  // Shift-add: netGrams is the multiplicand, op_b (frozen unit price) the multiplier.
  always_comb begin
    acc_next = acc;
    if (op_b[bit_idx]) acc_next = acc + (W_ACC'(bus.netGrams) << bit_idx);
  end

  assign bus.busy = (state != IDLE);

  balanca_div1000_seq u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (acc),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tare           <= '0;
      last_w         <= '0;
      op_b           <= '0;
      cnt            <= '0;
      tmo            <= '0;
      bit_idx        <= '0;
      acc            <= '0;
      div_start      <= 1'b0;
      bus.netGrams   <= '0;
      bus.precof     <= '0;
      bus.precoValid <= 1'b0;
      bus.overload   <= 1'b0;
      bus.errTimeout <= 1'b0;
    end else begin
      bus.precoValid <= 1'b0;
      div_start      <= 1'b0;
      case (state)
        IDLE: begin
          // Tare is written from the same sample that seeds the stability
          // check, so tare+start together prices a net of zero.
          if (bus.tareBtn) tare <= bus.weightInGrams;
          if (bus.start) begin
            state          <= SETTLE;
            last_w         <= bus.weightInGrams;
            cnt            <= 16'd1;
            tmo            <= '0;
            bus.errTimeout <= 1'b0;
            bus.overload   <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == STABLE_W) begin
            if (last_w > MAX_W) begin
              bus.overload   <= 1'b1;
              bus.precof     <= '0;
              bus.precoValid <= 1'b1;
              state          <= DONE;
            end else begin
              bus.netGrams <= net_now;
              op_b         <= bus.centimos;
              acc          <= '0;
              bit_idx      <= '0;
              state        <= MUL;
            end
          end else if (tmo == TMO_W) begin
            bus.errTimeout <= 1'b1;
            state          <= IDLE;
          end else begin
            tmo <= tmo + 16'd1;
            if (bus.weightInGrams == last_w) begin
              cnt <= cnt + 16'd1;
            end else begin
              cnt    <= 16'd1;
              last_w <= bus.weightInGrams;
            end
          end
        end
        MUL: begin
          if (bit_idx == LAST_BIT) begin
            acc       <= acc_next + ROUND_W;
            div_start <= 1'b1;
            state     <= DIV;
          end else begin
            acc     <= acc_next;
            bit_idx <= bit_idx + 4'd1;
          end
        end
        DIV: begin
          if (div_done) begin
            bus.precof     <= div_quo;
            bus.precoValid <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
